// File: rtl/quad_pkg.sv
// Shared constants for the four-channel ESC PWM generator.
package quad_pkg;
    localparam int SPD_W    = 11;
    localparam int NUM_CH   = 4;
    localparam int WDOG_LIM = 4;
    localparam int WDOG_W   = $clog2(WDOG_LIM + 1);

    typedef enum logic [1:0] {CH_FRNT, CH_BCK, CH_LFT, CH_RGHT} ch_e;
endpackage

// File: rtl/esc_pwm.sv
// One ESC channel: shadow/active speed registers and the frame-aligned PWM flop.
module esc_pwm
    import quad_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int MIN_PULSE = 50000,
    parameter int SPD_SH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PERIOD_W-1:0] cnt,
    input  logic                tc,
    input  logic                wrt,
    input  logic                zero_ld,
    input  logic [SPD_W-1:0]    spd,
    output logic                pwm
);
    logic [SPD_W-1:0]    shadow;
    logic [SPD_W-1:0]    active;
    logic [PERIOD_W-1:0] pulse;
    logic [PERIOD_W-1:0] pulse_end;

    // Active only changes at terminal count, so the pulse width is fixed for a whole frame.
    assign pulse     = PERIOD_W'(MIN_PULSE) + (PERIOD_W'(active) << SPD_SH);
    assign pulse_end = pulse - PERIOD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            pwm    <= 1'b0;
        end else begin
            if (wrt)
                shadow <= spd;
            if (tc) begin
                if (zero_ld)
                    active <= '0;
                else if (wrt)
                    active <= spd;
                else
                    active <= shadow;
            end
            if (tc)
                pwm <= 1'b1;
            else if (cnt == pulse_end)
                pwm <= 1'b0;
        end
    end
endmodule

// File: rtl/esc_quad.sv
// Quad ESC PWM generator sharing one frame counter across four channels.
// Define ESC_WDOG_EN to zero all speeds after four frames with no write.
module esc_quad
    import quad_pkg::*;
#(
    parameter int PERIOD_W  = 20,
    parameter int MIN_PULSE = 50000,
    parameter int SPD_SH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrt,
    input  logic [SPD_W-1:0] frnt_spd,
    input  logic [SPD_W-1:0] bck_spd,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] rght_spd,
    output logic             frnt,
    output logic             bck,
    output logic             lft,
    output logic             rght,
    output logic             frm_end
);
    logic [PERIOD_W-1:0]          cnt;
    logic                         tc;
    logic                         zero_ld;
    logic [NUM_CH-1:0][SPD_W-1:0] spd_bus;
    logic [NUM_CH-1:0]            pwm;

    assign tc = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            frm_end <= 1'b0;
        end else begin
            cnt     <= cnt + PERIOD_W'(1);
            frm_end <= tc;
        end
    end

`ifdef ESC_WDOG_EN
    logic [WDOG_W-1:0] wd_cnt;
    logic              wd_seen;

    // A write anywhere in the closing frame (including at terminal count) keeps the link alive.
    assign zero_ld = tc && !wrt && !wd_seen && (wd_cnt >= WDOG_W'(WDOG_LIM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            wd_seen <= 1'b0;
        end else if (tc) begin
            wd_seen <= 1'b0;
            if (wrt || wd_seen)
                wd_cnt <= '0;
            else if (wd_cnt != WDOG_W'(WDOG_LIM))
                wd_cnt <= wd_cnt + WDOG_W'(1);
        end else if (wrt) begin
            wd_cnt  <= '0;
            wd_seen <= 1'b1;
        end
    end
`else
    assign zero_ld = 1'b0;
`endif

    assign spd_bus[CH_FRNT] = frnt_spd;
    assign spd_bus[CH_BCK]  = bck_spd;
    assign spd_bus[CH_LFT]  = lft_spd;
    assign spd_bus[CH_RGHT] = rght_spd;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        esc_pwm #(
            .PERIOD_W (PERIOD_W),
            .MIN_PULSE(MIN_PULSE),
            .SPD_SH   (SPD_SH)
        ) u_pwm (
            .clk    (clk),
            .rst_n  (rst_n),
            .cnt    (cnt),
            .tc     (tc),
            .wrt    (wrt),
            .zero_ld(zero_ld),
            .spd    (spd_bus[i]),
            .pwm    (pwm[i])
        );
    end

    assign frnt = pwm[CH_FRNT];
    assign bck  = pwm[CH_BCK];
    assign lft  = pwm[CH_LFT];
    assign rght = pwm[CH_RGHT];
endmodule
